bus_arb_rr: RTL
===============

BUS_ARB_RR -- requirements
Module: bus_arb_rr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of bus requesters, legal range 2..8.
REQ-002 SHALL have parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-003 SHALL have parameter MAX_HOLD, default 0: grant-hold limit in cycles, 0 = unlimited, legal range 0..65535.
REQ-004 SHALL define OWNER_W = max(1, clog2(NUM_PORTS)).
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port busreq, input, NUM_PORTS: per-port bus request.
REQ-008 SHALL have port busidle, input, NUM_PORTS: per-port flag, high when that port has no bus transaction in flight.
REQ-009 SHALL have port busgrant, output, NUM_PORTS: one-hot or zero grant vector, registered.
REQ-010 SHALL have port owner, output, OWNER_W: index of the granted port, valid only while busy is high.
REQ-011 SHALL have port busy, output, 1: high while any grant bit is high.
REQ-012 SHALL have port preempt, output, 1: one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-013 SHALL implement states IDLE, GRANT and RELEASE.
REQ-014 In IDLE or RELEASE, when any busreq bit is high, SHALL select a winner, assert its busgrant bit on the next edge and enter GRANT; when none is high, SHALL enter or stay in IDLE.
REQ-015 Grant latency: busreq sampled high at edge k SHALL give busgrant visible after edge k, assuming the bus is free.
REQ-016 In PRIO_MODE 0, the search SHALL start at (last_owner+1) mod NUM_PORTS and wrap; last_owner updates only when a grant is issued.
REQ-017 In PRIO_MODE 1, the lowest-index requester SHALL win.
REQ-018 busgrant SHALL never have more than one bit high; owner SHALL equal the index of that bit.
REQ-019 In GRANT, when the owner's busreq is low and its busidle is high at the same edge, SHALL clear busgrant and enter RELEASE.
REQ-020 In GRANT, if the owner drops busreq while busidle is low, SHALL hold the grant until busidle goes high.
REQ-021 RELEASE SHALL last exactly one cycle with busgrant all zero, giving a mandatory one-cycle turnaround between owners.
REQ-022 hold_cnt (16 bits) SHALL clear on grant issue, increment each cycle in GRANT, and saturate at 65535.
REQ-023 When MAX_HOLD>0, hold_cnt>=MAX_HOLD, the owner's busidle is high and any other port's busreq is high, SHALL revoke the grant, enter RELEASE and pulse preempt for one cycle.
REQ-024 A preempted owner SHALL never be selected in the following arbitration if any other port requests; in PRIO_MODE 1, the preempted port is skipped for that one arbitration.
REQ-025 Preemption SHALL never occur while the owner's busidle is low, so no in-flight transaction is cut.
REQ-026 A request from a non-owner during GRANT SHALL be held pending, with no loss and no effect on the current grant.
REQ-027 When the owner releases and others request in the same cycle, the RELEASE-cycle arbitration SHALL serve them.
REQ-028 A single requester that keeps busreq high SHALL retain the grant indefinitely; preemption requires a competing request.

Reset
REQ-029 While reset is low: busgrant=0, owner=0, busy=0, preempt=0, hold_cnt=0, state=IDLE, last_owner=NUM_PORTS-1 so port 0 is searched first.
REQ-030 Reset asserted mid-GRANT SHALL clear busgrant immediately and asynchronously; the first arbitration occurs at the first edge after reset deasserts.

Verification
REQ-031 NUM_PORTS=4, PRIO_MODE=0, busreq=4'b1111 held, each owner releases after 3 cycles -> grants issued in order 0,1,2,3,0 with one zero-grant cycle between each.
REQ-032 PRIO_MODE=1, busreq=4'b1010 -> port 1 granted; after port 1 releases with busreq=4'b1000 -> port 3 granted after one RELEASE cycle.
REQ-033 MAX_HOLD=5, port 0 holds busreq with busidle=1, port 2 requests at cycle 2 -> revoke at hold_cnt=5, preempt pulses once, port 2 granted next.
REQ-034 MAX_HOLD=5, owner busidle=0 through cycle 9 -> no preempt until busidle rises, then revoke on that edge.
REQ-035 Owner drops busreq with busidle=0 for 4 cycles -> grant held 4 more cycles, then RELEASE.
REQ-036 Reset pulled low mid-GRANT -> busgrant=0 and busy=0 without a clock edge; after release with busreq=4'b0110 -> port 1 granted first.

Source files
------------

// File: rtl/bus_arb_rr.sv
// Bus arbiter for NUM_PORTS requesters: round-robin or fixed priority, registered
// one-hot grant, one-cycle RELEASE turnaround and an optional grant-hold limit.
module bus_arb_rr #(
  parameter int NUM_PORTS = 2,
  parameter int PRIO_MODE = 0,
  parameter int MAX_HOLD  = 0,
  localparam int OWNER_W  = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] busreq,
  input  logic [NUM_PORTS-1:0] busidle,
  output logic [NUM_PORTS-1:0] busgrant,
  output logic [OWNER_W-1:0]   owner,
  output logic                 busy,
  output logic                 preempt,
  output logic [1:0]           state_dbg
);

  // Handshake: a port holds busreq high until it sees its busgrant bit; it keeps
  // ownership while busreq is high or busidle is low, and gives the bus back by
  // presenting busreq low together with busidle high on the same clock edge.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_PORTS-1:0]   grant_nxt;
  logic [OWNER_W-1:0]     owner_nxt;
  logic                   busy_nxt;
  logic                   preempt_nxt;
  logic [15:0]            hold_cnt, hold_nxt;
  logic [OWNER_W-1:0]     last_owner, last_nxt;
  logic                   skip_valid, skip_valid_nxt;
  logic [OWNER_W-1:0]     skip_port, skip_port_nxt;

  logic [NUM_PORTS-1:0]   skip_mask;
  logic [NUM_PORTS-1:0]   cand;
  logic [NUM_PORTS-1:0]   others_req;
  logic [OWNER_W-1:0]     win;
  logic                   found;
  logic                   hold_at_limit;
  int                     idx;

  assign state_dbg     = state;
  assign skip_mask     = NUM_PORTS'(1) << skip_port;
  assign others_req    = busreq & ~busgrant;
  assign hold_at_limit = (MAX_HOLD > 0) && (32'(hold_cnt) >= 32'(MAX_HOLD));

  // A just-preempted port sits out one arbitration, unless it is the only requester.
  always_comb begin
    cand  = busreq;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (skip_valid && ((busreq & ~skip_mask) != '0)) cand = busreq & ~skip_mask;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (PRIO_MODE == 1) ? i : (int'(last_owner) + 1 + i) % NUM_PORTS;
      if (!found && cand[idx]) begin
        win   = OWNER_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = busgrant;
    owner_nxt      = owner;
    busy_nxt       = busy;
    preempt_nxt    = 1'b0;
    hold_nxt       = hold_cnt;
    last_nxt       = last_owner;
    skip_valid_nxt = skip_valid;
    skip_port_nxt  = skip_port;
    case (state)
      ST_GRANT: begin
        if (!busreq[owner] && busidle[owner]) begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          state_nxt = ST_RELEASE;
        end else if (hold_at_limit && busidle[owner] && (others_req != '0)) begin
          grant_nxt      = '0;
          busy_nxt       = 1'b0;
          preempt_nxt    = 1'b1;
          skip_valid_nxt = 1'b1;
          skip_port_nxt  = owner;
          state_nxt      = ST_RELEASE;
        end else if (hold_cnt != 16'hFFFF) begin
          hold_nxt = hold_cnt + 16'd1;
        end
      end
      default: begin
        // IDLE and RELEASE arbitrate the same way; the skip applies to one round only.
        skip_valid_nxt = 1'b0;
        if (found) begin
          grant_nxt = NUM_PORTS'(1) << win;
          owner_nxt = win;
          busy_nxt  = 1'b1;
          hold_nxt  = 16'd0;
          last_nxt  = win;
          state_nxt = ST_GRANT;
        end else begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busgrant   <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      preempt    <= 1'b0;
      hold_cnt   <= 16'd0;
      last_owner <= OWNER_W'(NUM_PORTS - 1);
      skip_valid <= 1'b0;
      skip_port  <= '0;
    end else begin
      state      <= state_nxt;
      busgrant   <= grant_nxt;
      owner      <= owner_nxt;
      busy       <= busy_nxt;
      preempt    <= preempt_nxt;
      hold_cnt   <= hold_nxt;
      last_owner <= last_nxt;
      skip_valid <= skip_valid_nxt;
      skip_port  <= skip_port_nxt;
    end
  end

endmodule
